// File: rtl/sram_emu_pkg.sv
// sram_emu_pkg: shared widths, bus fill word and stability counter limit for the SRAM emulator.
package sram_emu_pkg;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 23;
    localparam logic [DATA_W-1:0] FILL_WORD = 16'hDEAD;
    localparam logic [1:0] CNT_MAX = 2'd3;
endpackage

// File: rtl/sram_emu_array.sv
// sram_emu_array: 2^AW x 16 storage with byte-lane writes and a registered, write-first read port.
module sram_emu_array
    import sram_emu_pkg::*;
#(
    parameter int AW = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_we_lo,
    input  logic              i_we_hi,
    input  logic [AW-1:0]     i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [AW-1:0]     i_raddr,
    output logic [DATA_W-1:0] o_rdata
);
    logic [DATA_W-1:0] r_mem [2**AW];
    logic [DATA_W-1:0] r_rdata;
    logic [DATA_W-1:0] w_word;
    logic [DATA_W-1:0] w_fwd;
    logic              w_hit;

    assign w_word  = r_mem[i_raddr];
    assign w_hit   = i_waddr == i_raddr;
    assign w_fwd   = {(w_hit && i_we_hi) ? i_wdata[15:8] : w_word[15:8],
                      (w_hit && i_we_lo) ? i_wdata[7:0]  : w_word[7:0]};
    assign o_rdata = r_rdata;

    // Contents survive reset; only the read register is cleared.
    always_ff @(posedge clk) begin
        if (i_we_lo) r_mem[i_waddr][7:0] <= i_wdata[7:0];
        if (i_we_hi) r_mem[i_waddr][15:8] <= i_wdata[15:8];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_rdata <= '0;
        else r_rdata <= w_fwd;
    end
endmodule

// File: rtl/sram_emu.sv
// sram_emu: async-SRAM / PSRAM pin emulator committing writes on the rising edge of WE,
// with a config register selected by CRE and a stability-gated read data bus.
module sram_emu
    import sram_emu_pkg::*;
#(
    parameter int AW       = 12,
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W:1]   sram_addr,
    input  logic              sram_ce,
    input  logic              sram_oe,
    input  logic              sram_we,
    input  logic              sram_lb,
    input  logic              sram_ub,
    input  logic              sram_cre,
    input  logic              sram_adv,
    input  logic              sram_clk,
    inout  wire  [DATA_W-1:0] sram_data,
    output logic [DATA_W-1:0] cfg_reg,
    output logic [DATA_W-1:0] wr_count,
    output logic [DATA_W-1:0] rd_count
);
    localparam logic [1:0] LAT = 2'(READ_LAT);

    logic [ADDR_W:1]   r_addr_q;
    logic [DATA_W-1:0] r_wdata_q;
    logic              r_we_q;
    logic              r_lb_q;
    logic              r_ub_q;
    logic              r_cre_q;
    logic [1:0]        r_cnt;
    logic [DATA_W-1:0] r_cfg;
    logic [DATA_W-1:0] r_wr_cnt;
    logic [DATA_W-1:0] r_rd_cnt;

    logic              w_rd;
    logic              w_commit;
    logic              w_arr_wr;
    logic              w_cfg_wr;
    logic              w_rd_done;
    logic [1:0]        w_cnt_nxt;
    logic [DATA_W-1:0] w_rdata;
    logic [DATA_W-1:0] w_dout;
    logic              w_unused;

    assign w_unused  = ^{sram_adv, sram_clk};
    assign w_rd      = !sram_ce && !sram_oe && sram_we && !sram_cre;
    assign w_commit  = !r_we_q && sram_we && !sram_ce;
    assign w_arr_wr  = w_commit && !r_cre_q;
    assign w_cfg_wr  = w_commit && r_cre_q;
    assign w_cnt_nxt = (!w_rd || sram_addr != r_addr_q) ? 2'd0 :
                       (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 2'd1;
    assign w_rd_done = w_cnt_nxt == LAT && r_cnt != LAT;
    assign w_dout    = (r_cnt >= LAT) ? w_rdata : FILL_WORD;

    // Enables are pure pin logic so the bus turns around in the same cycle WE moves.
    assign sram_data[7:0]  = (w_rd && !sram_lb) ? w_dout[7:0]  : 8'hzz;
    assign sram_data[15:8] = (w_rd && !sram_ub) ? w_dout[15:8] : 8'hzz;

    assign cfg_reg  = r_cfg;
    assign wr_count = r_wr_cnt;
    assign rd_count = r_rd_cnt;

    sram_emu_array #(.AW(AW)) u_array (
        .clk     (clk),
        .rst     (rst),
        .i_we_lo (w_arr_wr && !r_lb_q),
        .i_we_hi (w_arr_wr && !r_ub_q),
        .i_waddr (r_addr_q[AW:1]),
        .i_wdata (r_wdata_q),
        .i_raddr (sram_addr[AW:1]),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_addr_q  <= '0;
            r_wdata_q <= '0;
            r_we_q    <= 1'b1;
            r_lb_q    <= 1'b1;
            r_ub_q    <= 1'b1;
            r_cre_q   <= 1'b0;
            r_cnt     <= 2'd0;
            r_cfg     <= '0;
            r_wr_cnt  <= '0;
            r_rd_cnt  <= '0;
        end else begin
            r_addr_q  <= sram_addr;
            r_wdata_q <= sram_data;
            r_we_q    <= sram_we;
            r_lb_q    <= sram_lb;
            r_ub_q    <= sram_ub;
            r_cre_q   <= sram_cre;
            r_cnt     <= w_cnt_nxt;
            if (w_cfg_wr) r_cfg <= {r_ub_q ? r_cfg[15:8] : r_wdata_q[15:8],
                                    r_lb_q ? r_cfg[7:0]  : r_wdata_q[7:0]};
            if (w_arr_wr) r_wr_cnt <= r_wr_cnt + 16'd1;
            if (w_rd_done) r_rd_cnt <= r_rd_cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_sram_emu.sv
// tb_sram_emu: scenario bench for sram_emu driving the SRAM pin protocol, with a queue of expected bus reads.
module tb_sram_emu;
    localparam int RL = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:1] addr;
    logic        ce, oe, we, lb, ub, cre, adv, sclk;
    logic        tb_drv;
    logic [15:0] tb_wdata;
    wire  [15:0] sram_data;
    logic [15:0] cfg_reg, wr_count, rd_count;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [15:0] exp_q[$];

    always #5 clk = ~clk;

    assign sram_data = tb_drv ? tb_wdata : 16'hzzzz;

    sram_emu #(.AW(12), .READ_LAT(RL)) dut (
        .clk       (clk),
        .rst       (rst),
        .sram_addr (addr),
        .sram_ce   (ce),
        .sram_oe   (oe),
        .sram_we   (we),
        .sram_lb   (lb),
        .sram_ub   (ub),
        .sram_cre  (cre),
        .sram_adv  (adv),
        .sram_clk  (sclk),
        .sram_data (sram_data),
        .cfg_reg   (cfg_reg),
        .wr_count  (wr_count),
        .rd_count  (rd_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_word(input logic [23:1] a, input logic [15:0] d, input int low,
                           input logic l, input logic u);
        ce = 0; oe = 1; we = 0; cre = 0; addr = a; tb_wdata = d; lb = l; ub = u; tb_drv = 1;
        repeat (low) tick();
        we = 1; tb_drv = 0;
        tick();
        lb = 0; ub = 0;
    endtask

    task automatic rd_word(input logic [23:1] a, output logic [15:0] got);
        ce = 0; oe = 0; we = 1; cre = 0; lb = 0; ub = 0; tb_drv = 0; addr = a;
        repeat (RL + 1) tick();
        got = sram_data;
        oe = 1;
    endtask

    task automatic test_reset();
        logic [15:0] e;
        rst = 0; adv = 0; sclk = 0; lb = 0; ub = 0; cre = 0; tb_drv = 0; tb_wdata = 0;
        ce = 0; oe = 0; we = 1; addr = 23'h7;
        exp_q.push_back(16'hDEAD);
        tick(); tick();
        e = exp_q.pop_front();
        n_checks++; if (sram_data !== e) begin n_fail++; $display("FAIL rst_bus: got %h want %h", sram_data, e); end
        n_checks++; if (cfg_reg !== 16'h0) begin n_fail++; $display("FAIL rst_cfg: got %h want 0000", cfg_reg); end
        n_checks++; if (wr_count !== 16'h0) begin n_fail++; $display("FAIL rst_wr: got %h want 0000", wr_count); end
        n_checks++; if (rd_count !== 16'h0) begin n_fail++; $display("FAIL rst_rd: got %h want 0000", rd_count); end
        oe = 1; ce = 1;
        tick();
        rst = 1;
        tick();
    endtask

    task automatic test_write32();
        logic [15:0] g0, g1, e;
        wr_word(23'h20, 16'h1234, 2, 0, 0);
        wr_word(23'h21, 16'h5678, 2, 0, 0);
        n_checks++; if (wr_count !== 16'd2) begin n_fail++; $display("FAIL w32_wr_count: got %0d want 2", wr_count); end
        exp_q.push_back(16'h1234);
        exp_q.push_back(16'h5678);
        rd_word(23'h20, g0);
        rd_word(23'h21, g1);
        e = exp_q.pop_front();
        n_checks++; if (g0 !== e) begin n_fail++; $display("FAIL w32_hi: got %h want %h", g0, e); end
        e = exp_q.pop_front();
        n_checks++; if (g1 !== e) begin n_fail++; $display("FAIL w32_lo: got %h want %h", g1, e); end
    endtask

    task automatic test_read_latency();
        logic [15:0] rc0, e;
        rc0 = rd_count;
        exp_q.push_back(16'hDEAD);
        exp_q.push_back(16'h1234);
        ce = 0; oe = 0; we = 1; addr = 23'h20;
        tick();
        e = exp_q.pop_front();
        n_checks++; if (sram_data !== e) begin n_fail++; $display("FAIL lat_1cyc: got %h want %h", sram_data, e); end
        n_checks++; if (rd_count !== rc0) begin n_fail++; $display("FAIL lat_rc_early: got %0d want %0d", rd_count, rc0); end
        tick();
        e = exp_q.pop_front();
        n_checks++; if (sram_data !== e) begin n_fail++; $display("FAIL lat_2cyc: got %h want %h", sram_data, e); end
        n_checks++; if (rd_count !== rc0 + 16'd1) begin n_fail++; $display("FAIL lat_rc_once: got %0d want %0d", rd_count, rc0 + 16'd1); end
        tick(); tick();
        n_checks++; if (rd_count !== rc0 + 16'd1) begin n_fail++; $display("FAIL lat_rc_hold: got %0d want %0d", rd_count, rc0 + 16'd1); end
        oe = 1;
        tick();
    endtask

    task automatic test_byte_lane();
        logic [15:0] g, e;
        wr_word(23'h30, 16'h1122, 2, 0, 0);
        wr_word(23'h30, 16'hAABB, 2, 0, 1);
        exp_q.push_back(16'h11BB);
        rd_word(23'h30, g);
        e = exp_q.pop_front();
        n_checks++; if (g !== e) begin n_fail++; $display("FAIL lane_lo: got %h want %h", g, e); end
        wr_word(23'h30, 16'h3344, 1, 1, 0);
        exp_q.push_back(16'h33BB);
        rd_word(23'h30, g);
        e = exp_q.pop_front();
        n_checks++; if (g !== e) begin n_fail++; $display("FAIL lane_hi: got %h want %h", g, e); end
    endtask

    task automatic test_cre();
        logic [15:0] wc, g, e;
        wc = wr_count;
        ce = 0; oe = 1; cre = 1; we = 0; addr = 23'h20; tb_wdata = 16'h0090; tb_drv = 1;
        tick(); tick();
        we = 1; tb_drv = 0;
        tick();
        cre = 0;
        n_checks++; if (cfg_reg !== 16'h0090) begin n_fail++; $display("FAIL cre_cfg: got %h want 0090", cfg_reg); end
        n_checks++; if (wr_count !== wc) begin n_fail++; $display("FAIL cre_wr_count: got %0d want %0d", wr_count, wc); end
        exp_q.push_back(16'h1234);
        rd_word(23'h20, g);
        e = exp_q.pop_front();
        n_checks++; if (g !== e) begin n_fail++; $display("FAIL cre_array: got %h want %h", g, e); end
    endtask

    task automatic test_write_first();
        logic [15:0] wc, e;
        wr_word(23'h40, 16'h0404, 2, 0, 0);
        wc = wr_count;
        ce = 0; oe = 0; we = 0; addr = 23'h41; tb_wdata = 16'h4444; tb_drv = 1;
        tick();
        addr = 23'h40;
        tick();
        we = 1; tb_drv = 0;
        exp_q.push_back(16'h4444);
        tick();
        e = exp_q.pop_front();
        n_checks++; if (sram_data !== e) begin n_fail++; $display("FAIL wfirst_bus: got %h want %h", sram_data, e); end
        n_checks++; if (wr_count !== wc + 16'd1) begin n_fail++; $display("FAIL wfirst_wr: got %0d want %0d", wr_count, wc + 16'd1); end
        oe = 1;
        tick();
    endtask

    task automatic test_addr_change();
        logic [15:0] g0, g1, e;
        wr_word(23'h51, 16'h5151, 2, 0, 0);
        ce = 0; oe = 1; we = 0; addr = 23'h50; tb_wdata = 16'hBEEF; tb_drv = 1;
        tick(); tick();
        we = 1; tb_drv = 0; addr = 23'h51;
        tick();
        exp_q.push_back(16'hBEEF);
        exp_q.push_back(16'h5151);
        rd_word(23'h50, g0);
        rd_word(23'h51, g1);
        e = exp_q.pop_front();
        n_checks++; if (g0 !== e) begin n_fail++; $display("FAIL achg_old: got %h want %h", g0, e); end
        e = exp_q.pop_front();
        n_checks++; if (g1 !== e) begin n_fail++; $display("FAIL achg_new: got %h want %h", g1, e); end
    endtask

    task automatic test_alias_and_short_we();
        logic [15:0] g0, g1, e;
        wr_word(23'h1060, 16'hC0DE, 2, 0, 0);
        wr_word(23'h70, 16'h7777, 1, 0, 0);
        exp_q.push_back(16'hC0DE);
        exp_q.push_back(16'h7777);
        rd_word(23'h060, g0);
        rd_word(23'h70, g1);
        e = exp_q.pop_front();
        n_checks++; if (g0 !== e) begin n_fail++; $display("FAIL alias: got %h want %h", g0, e); end
        e = exp_q.pop_front();
        n_checks++; if (g1 !== e) begin n_fail++; $display("FAIL we_1cyc: got %h want %h", g1, e); end
    endtask

    task automatic test_reset_during_write();
        logic [15:0] g, e;
        ce = 0; oe = 1; we = 0; cre = 0; addr = 23'h20; tb_wdata = 16'hFFFF; tb_drv = 1;
        tick();
        rst = 0;
        tick();
        we = 1; tb_drv = 0;
        tick();
        rst = 1;
        tick();
        n_checks++; if (wr_count !== 16'h0) begin n_fail++; $display("FAIL rstw_wr: got %0d want 0", wr_count); end
        n_checks++; if (rd_count !== 16'h0) begin n_fail++; $display("FAIL rstw_rd: got %0d want 0", rd_count); end
        n_checks++; if (cfg_reg !== 16'h0) begin n_fail++; $display("FAIL rstw_cfg: got %h want 0000", cfg_reg); end
        exp_q.push_back(16'h1234);
        rd_word(23'h20, g);
        e = exp_q.pop_front();
        n_checks++; if (g !== e) begin n_fail++; $display("FAIL rstw_array: got %h want %h", g, e); end
    endtask

    initial begin
        test_reset();
        test_write32();
        test_read_latency();
        test_byte_lane();
        test_cre();
        test_write_first();
        test_addr_change();
        test_alias_and_short_we();
        test_reset_during_write();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
